// File: rtl/sync_down_timer_pkg.sv
// Shared constants for the synchronous down-timer: FSM state encoding and default width.
// Optional feature macro used by this block: SYNC_DOWN_TIMER_AUTO_RELOAD_EN.
package sync_timer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

endpackage

// File: rtl/sync_down_timer_if.sv
// Control/status bundle between a controlling FSM (master) and the down-timer (slave).
// The periodic pin exists only when SYNC_DOWN_TIMER_AUTO_RELOAD_EN is defined.
interface sync_down_timer_if #(
  parameter int WIDTH = sync_timer_pkg::DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             en;
`ifdef SYNC_DOWN_TIMER_AUTO_RELOAD_EN
  logic             periodic;
`endif
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             tc;

`ifdef SYNC_DOWN_TIMER_AUTO_RELOAD_EN
  modport master (output start, load_val, en, periodic, input q, busy, tc);
  modport slave  (input start, load_val, en, periodic, output q, busy, tc);
`else
  modport master (output start, load_val, en, input q, busy, tc);
  modport slave  (input start, load_val, en, output q, busy, tc);
`endif

endinterface

// File: rtl/sync_down_timer_down_cnt_core.sv
// WIDTH-bit count register with synchronous clear, load and saturating decrement.
// is_one tells the controlling FSM that the next enabled tick is the terminal one.
module down_cnt_core
  import sync_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] cnt,
  output logic             is_one
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Load beats decrement; a zero count never decrements, so q cannot wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  assign is_one = (cnt_q == ONE);

endmodule

// File: rtl/sync_down_timer.sv
// Loadable down-timer: FSM, reload register and terminal-count pulse around down_cnt_core.
// Define SYNC_DOWN_TIMER_AUTO_RELOAD_EN to add periodic auto-reload via bus.periodic.
module sync_down_timer
  import sync_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic               clk,
  input logic               reset,
  sync_down_timer_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  logic             core_load;
  logic [WIDTH-1:0] core_load_val;
  logic             core_dec;
  logic [WIDTH-1:0] core_cnt;
  logic             core_is_one;

  always_comb begin
    state_d       = state_q;
    reload_d      = reload_q;
    tc_d          = 1'b0;
    core_load     = 1'b0;
    core_load_val = bus.load_val;
    core_dec      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          core_load = 1'b1;
          if (bus.load_val != '0) begin
            reload_d = bus.load_val;
            state_d  = ST_COUNT;
          end else begin
            tc_d = 1'b1;
          end
        end
      end
      ST_COUNT: begin
        // A restart takes precedence over any enabled decrement this cycle.
        if (bus.start) begin
          core_load = 1'b1;
          reload_d  = bus.load_val;
          if (bus.load_val == '0) begin
            tc_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (bus.en) begin
          if (core_is_one) begin
            tc_d = 1'b1;
`ifdef SYNC_DOWN_TIMER_AUTO_RELOAD_EN
            if (bus.periodic) begin
              core_load     = 1'b1;
              core_load_val = reload_q;
            end else begin
              core_dec = 1'b1;
              state_d  = ST_IDLE;
            end
`else
            core_dec = 1'b1;
            state_d  = ST_IDLE;
`endif
          end else begin
            core_dec = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  down_cnt_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (core_load),
    .load_val (core_load_val),
    .dec      (core_dec),
    .cnt      (core_cnt),
    .is_one   (core_is_one)
  );

  assign bus.q    = core_cnt;
  assign bus.busy = (state_q == ST_COUNT);
  assign bus.tc   = tc_q;

endmodule

// File: tb/tb_sync_down_timer.sv
// Self-checking bench for sync_down_timer: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the timer rules.
module tb_sync_down_timer;

  localparam int W = 4;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] m_q;
  logic [W-1:0] m_reload;
  logic         m_busy;
  logic         m_tc;

  sync_down_timer_if #(.WIDTH(W)) bus ();

  sync_down_timer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic periodic_in();
`ifdef SYNC_DOWN_TIMER_AUTO_RELOAD_EN
    return bus.periodic;
`else
    return 1'b0;
`endif
  endfunction

  // Timer rules as observed from outside: remaining count, whether it is running, last pulse.
  task automatic model_update();
    m_tc = 1'b0;
    if (reset) begin
      m_q      = '0;
      m_busy   = 1'b0;
      m_reload = '0;
    end else if (bus.start) begin
      m_reload = bus.load_val;
      if (bus.load_val == '0) begin
        m_q    = '0;
        m_busy = 1'b0;
        m_tc   = 1'b1;
      end else begin
        m_q    = bus.load_val;
        m_busy = 1'b1;
      end
    end else if (m_busy && bus.en) begin
      if (m_q == 1) begin
        m_tc = 1'b1;
        if (periodic_in()) begin
          m_q = m_reload;
        end else begin
          m_q    = '0;
          m_busy = 1'b0;
        end
      end else begin
        m_q = W'(int'(m_q) - 1);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({bus.q, bus.busy, bus.tc} !== {4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_initial got q=%0d busy=%b tc=%b want q=0 busy=0 tc=0", bus.q, bus.busy, bus.tc);
    end
    reset = 1'b0;
    bus.start = 1'b1; bus.load_val = 4'd7; bus.en = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    checks++;
    if (bus.q !== 4'd5) begin
      errors++;
      $display("FAIL reset_precount got q=%0d want q=5", bus.q);
    end
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if ({bus.q, bus.busy, bus.tc} !== {4'd0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_midcount k=%0d got q=%0d busy=%b tc=%b want q=0 busy=0 tc=0", k, bus.q, bus.busy, bus.tc);
      end
    end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({bus.q, bus.busy, bus.tc} !== {4'd0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_release k=%0d got q=%0d busy=%b tc=%b want q=0 busy=0 tc=0", k, bus.q, bus.busy, bus.tc);
      end
    end
    $display("txn reset mid-count done");
  endtask

  task automatic test_oneshot();
    int exp_q[4] = '{3, 2, 1, 0};
    bus.start = 1'b1; bus.load_val = 4'd3; bus.en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      bus.start = 1'b0;
      checks++;
      if ({bus.q, bus.busy, bus.tc} !== {4'(exp_q[k]), (k < 3), (k == 3)}) begin
        errors++;
        $display("FAIL oneshot cyc=%0d got q=%0d busy=%b tc=%b want q=%0d busy=%b tc=%b",
                 k + 1, bus.q, bus.busy, bus.tc, exp_q[k], (k < 3), (k == 3));
      end
    end
    $display("txn oneshot N=3 done");
  endtask

  task automatic test_pause();
    int   exp_q[7]  = '{4, 3, 3, 3, 2, 1, 0};
    logic en_pat[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bus.start = 1'b1; bus.load_val = 4'd4;
    for (int k = 0; k < 7; k++) begin
      bus.en = en_pat[k];
      step();
      bus.start = 1'b0;
      checks++;
      if ({bus.q, bus.busy, bus.tc} !== {4'(exp_q[k]), (k < 6), (k == 6)}) begin
        errors++;
        $display("FAIL pause cyc=%0d got q=%0d busy=%b tc=%b want q=%0d busy=%b tc=%b",
                 k + 1, bus.q, bus.busy, bus.tc, exp_q[k], (k < 6), (k == 6));
      end
    end
    bus.en = 1'b1;
    $display("txn pause N=4 done");
  endtask

  task automatic test_zero_restart();
    bus.start = 1'b1; bus.load_val = 4'd0; bus.en = 1'b1;
    step();
    bus.start = 1'b0;
    checks++;
    if ({bus.q, bus.busy, bus.tc} !== {4'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL zero_load got q=%0d busy=%b tc=%b want q=0 busy=0 tc=1", bus.q, bus.busy, bus.tc);
    end
    step();
    checks++;
    if ({bus.busy, bus.tc} !== 2'b00) begin
      errors++;
      $display("FAIL zero_after got busy=%b tc=%b want busy=0 tc=0", bus.busy, bus.tc);
    end
    bus.start = 1'b1; bus.load_val = 4'd8;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 6; k++) step();
    checks++;
    if (bus.q !== 4'd2) begin
      errors++;
      $display("FAIL restart_pre got q=%0d want q=2", bus.q);
    end
    bus.start = 1'b1; bus.load_val = 4'd6;
    step();
    bus.start = 1'b0;
    checks++;
    if ({bus.q, bus.busy, bus.tc} !== {4'd6, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL restart got q=%0d busy=%b tc=%b want q=6 busy=1 tc=0", bus.q, bus.busy, bus.tc);
    end
    $display("txn zero-load and restart N=6 done");
  endtask

  task automatic test_max();
    int tc_seen = 0;
    bus.start = 1'b1; bus.load_val = 4'd15; bus.en = 1'b1;
    step();
    bus.start = 1'b0;
    checks++;
    if ({bus.q, bus.busy, bus.tc} !== {4'd15, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL max_load got q=%0d busy=%b tc=%b want q=15 busy=1 tc=0", bus.q, bus.busy, bus.tc);
    end
    for (int k = 1; k <= 17; k++) begin
      step();
      if (bus.tc === 1'b1) tc_seen++;
      checks++;
      if ({bus.q, bus.tc} !== {4'((k <= 15) ? 15 - k : 0), (k == 15)}) begin
        errors++;
        $display("FAIL max_count k=%0d got q=%0d tc=%b want q=%0d tc=%b",
                 k, bus.q, bus.tc, (k <= 15) ? 15 - k : 0, (k == 15));
      end
    end
    checks++;
    if (tc_seen !== 1) begin
      errors++;
      $display("FAIL max_tc_count got %0d pulses want 1", tc_seen);
    end
    $display("txn max N=15 done");
  endtask

`ifdef SYNC_DOWN_TIMER_AUTO_RELOAD_EN
  task automatic test_periodic();
    bus.periodic = 1'b1;
    bus.start = 1'b1; bus.load_val = 4'd3; bus.en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      bus.start = 1'b0;
      checks++;
      if ({bus.q, bus.busy, bus.tc} !== {4'(3 - ((k - 1) % 3)), 1'b1, (k > 1) && ((k - 1) % 3 == 0)}) begin
        errors++;
        $display("FAIL periodic cyc=%0d got q=%0d busy=%b tc=%b want q=%0d busy=1 tc=%b",
                 k, bus.q, bus.busy, bus.tc, 3 - ((k - 1) % 3), (k > 1) && ((k - 1) % 3 == 0));
      end
    end
    bus.periodic = 1'b0;
    $display("txn periodic N=3 done");
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      reset        = ($urandom_range(63) == 0);
      bus.start    = ($urandom_range(7) == 0);
      bus.load_val = W'($urandom);
      bus.en       = ($urandom_range(3) != 0);
`ifdef SYNC_DOWN_TIMER_AUTO_RELOAD_EN
      bus.periodic = $urandom_range(1) == 1;
`endif
      if (bus.start && !reset) $display("txn random start N=%0d at step %0d", bus.load_val, k);
      step();
      checks++;
      if ({bus.q, bus.busy, bus.tc} !== {m_q, m_busy, m_tc}) begin
        errors++;
        $display("FAIL random step=%0d got q=%0d busy=%b tc=%b want q=%0d busy=%b tc=%b",
                 k, bus.q, bus.busy, bus.tc, m_q, m_busy, m_tc);
      end
    end
    reset = 1'b0;
    bus.start = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.load_val = '0;
    bus.en       = 1'b0;
`ifdef SYNC_DOWN_TIMER_AUTO_RELOAD_EN
    bus.periodic = 1'b0;
`endif
    m_q = '0; m_reload = '0; m_busy = 1'b0; m_tc = 1'b0;
    test_reset();
    test_oneshot();
    test_pause();
    test_zero_restart();
    test_max();
`ifdef SYNC_DOWN_TIMER_AUTO_RELOAD_EN
    test_periodic();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
